// File: rtl/subtractor_serial_64bit_if.sv
// subtractor_serial_64bit_if: operand/result valid-ready bundle for the serial 64-bit subtractor.
interface subtractor_serial_64bit_if;
    logic        inValid;
    logic        inReady;
    logic [63:0] inA;
    logic [63:0] inB;
    logic        inBorrow;
    logic        outValid;
    logic        outReady;
    logic [63:0] outDiff;
    logic        outBorrow;
    logic        outZero;
    modport master (
        output inValid, inA, inB, inBorrow, outReady,
        input  inReady, outValid, outDiff, outBorrow, outZero
    );
    modport slave (
        input  inValid, inA, inB, inBorrow, outReady,
        output inReady, outValid, outDiff, outBorrow, outZero
    );
endinterface

// File: rtl/subtractor_serial_64bit.sv
// subtractor_serial_64bit: A - B - borrow over 64/CHUNK cycles using one CHUNK-wide slice.
module subtractor_serial_64bit #(
    parameter int CHUNK = 16
) (
    input logic                       clk,
    input logic                       rst_n,
    subtractor_serial_64bit_if.slave  bus
);
    localparam int NCHUNK = 64 / CHUNK;
    localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        state, state_nxt;
    logic [IW-1:0] idx;
    logic [63:0]   a_q, b_q, diff_q;
    logic          borrow_q;
    logic [CHUNK:0] slice;
    logic          last;
    // The extra top bit of the widened difference is the chunk's borrow-out.
    always_comb begin
        slice = {1'b0, a_q[idx*CHUNK +: CHUNK]} - {1'b0, b_q[idx*CHUNK +: CHUNK]}
              - {{CHUNK{1'b0}}, borrow_q};
        last  = idx == IW'(NCHUNK - 1);
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.inValid ? RUN : IDLE;
            RUN:     state_nxt = last ? DONE : RUN;
            DONE:    state_nxt = bus.outReady ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.inValid) begin
                a_q      <= bus.inA;
                b_q      <= bus.inB;
                borrow_q <= bus.inBorrow;
                idx      <= '0;
            end else if (state == RUN) begin
                diff_q[idx*CHUNK +: CHUNK] <= slice[CHUNK-1:0];
                borrow_q                   <= slice[CHUNK];
                idx                        <= last ? '0 : idx + 1'b1;
            end
        end
    end
    assign bus.inReady   = state == IDLE;
    assign bus.outValid  = state == DONE;
    assign bus.outDiff   = diff_q;
    assign bus.outBorrow = borrow_q;
    // Zero flag only reflects the completed result, never a partial one.
    assign bus.outZero   = state == DONE && diff_q == '0;
endmodule

// File: tb/tb_subtractor_serial_64bit.sv
// tb_subtractor_serial_64bit: randomized and directed checks against a 65-bit arithmetic model.
module tb_subtractor_serial_64bit;
    localparam int CHUNK = 16;
    localparam int NCHUNK = 64 / CHUNK;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    logic [63:0] exp_diff;
    logic        exp_borrow;
    subtractor_serial_64bit_if bus();
    subtractor_serial_64bit #(.CHUNK(CHUNK)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic model(input logic [63:0] a, input logic [63:0] b, input logic bi);
        logic [64:0] r;
        r = {1'b0, a} - {1'b0, b} - 65'(bi);
        exp_diff   = r[63:0];
        exp_borrow = r[64];
    endtask
    task automatic accept(input logic [63:0] a, input logic [63:0] b, input logic bi);
        check("ready_before_accept", 64'(bus.inReady), 64'd1);
        bus.inA = a; bus.inB = b; bus.inBorrow = bi; bus.inValid = 1'b1;
        model(a, b, bi);
        tick();
        bus.inValid = 1'b0;
        bus.inA = {$urandom, $urandom}; bus.inB = {$urandom, $urandom}; bus.inBorrow = $urandom_range(0, 1);
    endtask
    task automatic wait_result();
        int n = 0;
        while (!bus.outValid && n < 20) begin
            tick();
            n++;
        end
        check("latency", 64'(n), 64'(NCHUNK));
        check("diff", bus.outDiff, exp_diff);
        check("borrow", 64'(bus.outBorrow), 64'(exp_borrow));
        check("zero", 64'(bus.outZero), 64'(exp_diff == 64'd0));
        check("no_overlap", 64'(bus.inReady), 64'd0);
    endtask
    task automatic release_result();
        bus.outReady = 1'b1;
        tick();
        bus.outReady = 1'b0;
        check("valid_after_release", 64'(bus.outValid), 64'd0);
        check("ready_after_release", 64'(bus.inReady), 64'd1);
    endtask
    task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic bi);
        accept(a, b, bi);
        wait_result();
        release_result();
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [63:0] a, b, held;
        bus.inValid = 1'b0; bus.inA = '0; bus.inB = '0; bus.inBorrow = 1'b0; bus.outReady = 1'b0;
        #12;
        check("rst_inReady", 64'(bus.inReady), 64'd1);
        check("rst_outValid", 64'(bus.outValid), 64'd0);
        check("rst_outDiff", bus.outDiff, 64'd0);
        check("rst_outBorrow", 64'(bus.outBorrow), 64'd0);
        check("rst_outZero", 64'(bus.outZero), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        do_op(64'h10, 64'h1, 1'b0);
        do_op(64'h0, 64'h1, 1'b0);
        do_op(64'h0000_0000_0001_0000, 64'h1, 1'b0);
        do_op(64'd5, 64'd5, 1'b1);
        do_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0);
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
        // Backpressure: hold the result while new operands wiggle on the input side.
        accept(64'hDEAD_BEEF_0000_0001, 64'h0000_0001_0000_0002, 1'b1);
        wait_result();
        held = exp_diff;
        for (int i = 0; i < 5; i++) begin
            bus.inValid = 1'b1; bus.inA = {$urandom, $urandom}; bus.inB = {$urandom, $urandom};
            tick();
            check("bp_valid", 64'(bus.outValid), 64'd1);
            check("bp_diff", bus.outDiff, held);
            check("bp_borrow", 64'(bus.outBorrow), 64'(exp_borrow));
            check("bp_ready", 64'(bus.inReady), 64'd0);
        end
        a = 64'h0123_4567_89AB_CDEF; b = 64'hFEDC_BA98_7654_3210;
        bus.inA = a; bus.inB = b; bus.inBorrow = 1'b0;
        release_result();
        tick();
        bus.inValid = 1'b0;
        check("queued_accepted", 64'(bus.inReady), 64'd0);
        model(a, b, 1'b0);
        wait_result();
        release_result();
        // Abort mid-RUN with an asynchronous reset after two chunks are processed.
        accept(64'hFFFF_0000_FFFF_0000, 64'h0001_0001_0001_0001, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_outDiff", bus.outDiff, 64'd0);
        check("abort_outBorrow", 64'(bus.outBorrow), 64'd0);
        check("abort_outValid", 64'(bus.outValid), 64'd0);
        check("abort_inReady", 64'(bus.inReady), 64'd1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NCHUNK + 2; i++) begin
            tick();
            check("abort_no_valid", 64'(bus.outValid), 64'd0);
        end
        do_op(64'd7, 64'd3, 1'b0);
        for (int i = 0; i < 40; i++) begin
            a = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: b = {$urandom, $urandom};
                1: b = a;
                2: begin a = 64'($urandom_range(0, 3)); b = 64'($urandom_range(0, 3)); end
                default: b = a + 64'd1;
            endcase
            do_op(a, b, 1'($urandom_range(0, 1)));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/subtractor_serial_64bit.md
Name: subtractor_serial_64bit

Overview:
- Multi-cycle 64-bit unsigned subtractor with borrow-in and borrow-out, for area-constrained datapaths that cannot afford a duplicated parallel adder.
- Performs A - B - inBorrow by reusing one CHUNK-wide subtract slice across 64/CHUNK cycles, propagating the borrow between chunks through a register.
- Valid/ready handshake on both the operand side and the result side, so it can sit between a producer and consumer in the datapath.

Parameters:
- CHUNK, 16: bits processed per cycle. Legal values are 8, 16, 32 and 64. Must divide 64.
- NCHUNK, 64/CHUNK: derived localparam, not overridable. This is the number of RUN cycles.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- inValid  in  1  operand valid
- inReady  out  1  block can accept operands
- inA  in  64  minuend, unsigned
- inB  in  64  subtrahend, unsigned
- inBorrow  in  1  borrow-in
- outValid  out  1  result valid
- outReady  in  1  consumer accepts result
- outDiff  out  64  (inA - inB - inBorrow) mod 2^64
- outBorrow  out  1  1 iff inA < inB + inBorrow (unsigned compare, full precision)
- outZero  out  1  1 iff outDiff == 0

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, chunk index = 0.
  - inReady = 1, outValid = 0, outDiff = 0, outBorrow = 0, outZero = 0.
  - Internal operand and borrow registers are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - inReady = 1.
  - On a clock edge with inValid = 1, latch inA, inB and inBorrow into internal registers, set index = 0, and go to RUN.
  - With inValid = 0, stay in IDLE.
- RUN:
  - inReady = 0, outValid = 0.
  - Each edge computes {b, d} = A[idx] - B[idx] - borrow_reg on the CHUNK-wide slice idx.
  - d is written into the result register at bits idx*CHUNK +: CHUNK, and borrow_reg takes b.
  - idx increments by 1. The edge that processes idx = NCHUNK-1 moves the FSM to DONE.
- DONE:
  - outValid = 1.
  - outDiff, outBorrow and outZero are registered and stay stable until the handshake completes.
  - On an edge with outReady = 1, go to IDLE. inReady rises the following cycle.
  - With outReady = 0, hold indefinitely (backpressure). inValid is ignored.
- Latency:
  - Acceptance edge at E0 → outValid high after edge E0 + NCHUNK.
  - Minimum initiation interval is NCHUNK + 2 cycles.
  - For CHUNK = 16: outValid after 4 edges; one operation per 6 cycles.
- Arithmetic:
  - Borrow chain: the chunk-0 borrow-in is inBorrow; the chunk-k borrow-in is the chunk k-1 borrow-out.
  - outBorrow is the borrow-out of the last chunk.
  - outZero is derived from the final result register. Compute it in DONE or registered at DONE entry, never combinationally from partial results.
- Input rules:
  - Inputs are sampled only at the acceptance edge.
  - Operand changes during RUN or DONE have no effect.
- No overlap: inReady and outValid are never high in the same cycle.
- Reset mid-operation (RUN or DONE): the operation is aborted with no output handshake. All outputs return to their reset values, and after rst_n deasserts the block is in IDLE with inReady = 1.
- CHUNK = 64 degenerate case: RUN lasts exactly one cycle and behaviour is otherwise identical.

Test Plan:
- Basic subtract, CHUNK = 16: A = 0x10, B = 0x01, inBorrow = 0 → outDiff = 0xF, outBorrow = 0, outZero = 0. outValid rises exactly 4 edges after acceptance.
- Underflow: A = 0, B = 1, inBorrow = 0 → outDiff = 0xFFFF_FFFF_FFFF_FFFF, outBorrow = 1.
- Cross-chunk borrow: A = 0x0000_0000_0001_0000, B = 1 → outDiff = 0x0000_0000_0000_FFFF, outBorrow = 0.
- Borrow-in and zero flag:
  - A = B = 5, inBorrow = 1 → outDiff = all ones, outBorrow = 1.
  - A = B = 0x1234_5678_9ABC_DEF0, inBorrow = 0 → outDiff = 0, outZero = 1, outBorrow = 0.
- Backpressure:
  - Hold outReady = 0 for 5 cycles in DONE with inValid = 1 and inA/inB toggling → outputs stable, inReady = 0, no second acceptance.
  - Raise outReady → IDLE on that edge, inReady = 1 the next cycle, and the queued inValid is accepted on the following edge.
- Reset mid-RUN: pulse rst_n low at index 2 → outputs zero immediately (asynchronous), no outValid. A subsequent op A = 7, B = 3 → outDiff = 4.
